// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared constants for the 7-segment display path. The display encoder and
//   the capture-side decoder both use these patterns, so the two directions
//   agree by construction.
//   Contents:
//     SEG_0 .. SEG_9, SEG_BLANK : active-low patterns, bit 6 = g ... bit 0 = a
//     NIB_BLANK, NIB_ERR        : nibble codes for blank and illegal patterns
//     state_e                   : receiver FSM encoding (COLLECT, HOLD)
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] NIB_BLANK = 4'hF;
    localparam logic [3:0] NIB_ERR   = 4'hE;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational inverse of the 7-segment encoder.
//   Ports:
//     seg    in  7 : active-low segment pattern
//     nibble out 4 : recovered digit, NIB_BLANK for blank, NIB_ERR otherwise
//     blank  out 1 : pattern was the all-off blank pattern
//     err    out 1 : pattern is not a legal digit or blank
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       err
);

    always_comb begin
        nibble = NIB_ERR;
        blank  = 1'b0;
        err    = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'd0;
            SEG_1:     nibble = 4'd1;
            SEG_2:     nibble = 4'd2;
            SEG_3:     nibble = 4'd3;
            SEG_4:     nibble = 4'd4;
            SEG_5:     nibble = 4'd5;
            SEG_6:     nibble = 4'd6;
            SEG_7:     nibble = 4'd7;
            SEG_8:     nibble = 4'd8;
            SEG_9:     nibble = 4'd9;
            SEG_BLANK: begin
                nibble = NIB_BLANK;
                blank  = 1'b1;
            end
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_frame_rx.sv
// seg7_frame_rx
//   Collects NDIGITS active-low 7-segment patterns and recovers a packed
//   frame of nibbles with per-digit blank flags and a frame error flag.
//   Ports:
//     CLOCK_50   in  1          clock, rising edge
//     RESET_N    in  1          synchronous active-low reset
//     SEG_IN     in  7          segment pattern, bit 6 = g ... bit 0 = a
//     SEG_VALID  in  1          SEG_IN holds a digit
//     SEG_SOF    in  1          this digit is digit 0 of a new frame
//     SEG_READY  out 1          receiver accepts a digit this cycle
//     WORD       out 4*NDIGITS  decoded frame, digit 0 in the top nibble
//     BLANK_MASK out NDIGITS    bit NDIGITS-1-i set = digit i blank
//     FRAME_ERR  out 1          some digit in the frame was illegal
//     OUT_VALID  out 1          frame complete and stable
//     OUT_READY  in  1          consumer takes the frame
//     state_dbg  out state_e    current FSM state
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both 1. A sender holds its data while valid=1 and ready=0; ready
//   may depend on the receiver's state only, never on valid.
module seg7_frame_rx
    import seg7_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic [6:0]           SEG_IN,
    input  logic                 SEG_VALID,
    input  logic                 SEG_SOF,
    output logic                 SEG_READY,
    output logic [4*NDIGITS-1:0] WORD,
    output logic [NDIGITS-1:0]   BLANK_MASK,
    output logic                 FRAME_ERR,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output state_e               state_dbg
);

    localparam int CW = $clog2(NDIGITS + 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4*NDIGITS-1:0] word_q, word_d;
    logic [NDIGITS-1:0]   blank_q, blank_d;
    logic                 err_q, err_d;
    logic                 valid_q;

    logic [3:0]           dec_nib;
    logic                 dec_blank;
    logic                 dec_err;
    logic                 accept;
    logic [CW-1:0]        slot;
    logic                 last;

    seg7_decode u_decode (
        .seg    (SEG_IN),
        .nibble (dec_nib),
        .blank  (dec_blank),
        .err    (dec_err)
    );

    assign accept = SEG_VALID && SEG_READY;
    // SOF restarts the frame, so the digit lands in slot 0 regardless of cnt.
    assign slot   = SEG_SOF ? '0 : cnt_q;
    assign last   = (slot == CW'(NDIGITS - 1));

    // State register and datapath registers.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            word_q  <= '0;
            blank_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            blank_q <= blank_d;
            err_q   <= err_d;
            valid_q <= (state_d == HOLD);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept && last) state_d = HOLD;
            HOLD:    if (OUT_READY)      state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        SEG_READY = (state_q == COLLECT);
    end

    // Slot writes. Unwritten slots keep stale data; it is hidden by
    // OUT_VALID=0 until the frame is complete.
    always_comb begin
        cnt_d   = cnt_q;
        word_d  = word_q;
        blank_d = blank_q;
        err_d   = err_q;
        if (state_q == HOLD && OUT_READY) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (accept) begin
            if (SEG_SOF) begin
                blank_d = '0;
                err_d   = dec_err;
            end else begin
                err_d   = err_q | dec_err;
            end
            for (int i = 0; i < NDIGITS; i++) begin
                if (slot == CW'(i)) begin
                    word_d[4*(NDIGITS-i)-1 -: 4] = dec_nib;
                    blank_d[NDIGITS-1-i]         = dec_blank;
                end
            end
            cnt_d = last ? '0 : CW'(slot + 1'b1);
        end
    end

    assign WORD       = word_q;
    assign BLANK_MASK = blank_q;
    assign FRAME_ERR  = err_q;
    assign OUT_VALID  = valid_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_seg7_frame_rx.sv
module tb_seg7_frame_rx;
    import seg7_pkg::*;

    logic        CLOCK_50;
    logic        RESET_N;
    logic [6:0]  SEG_IN;
    logic        SEG_VALID;
    logic        SEG_SOF;
    logic        SEG_READY;
    logic [15:0] WORD;
    logic [3:0]  BLANK_MASK;
    logic        FRAME_ERR;
    logic        OUT_VALID;
    logic        OUT_READY;
    state_e      state_dbg;

    int checks   = 0;
    int failures = 0;

    seg7_frame_rx #(.NDIGITS(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .SEG_IN     (SEG_IN),
        .SEG_VALID  (SEG_VALID),
        .SEG_SOF    (SEG_SOF),
        .SEG_READY  (SEG_READY),
        .WORD       (WORD),
        .BLANK_MASK (BLANK_MASK),
        .FRAME_ERR  (FRAME_ERR),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .state_dbg  (state_dbg)
    );

    // Clock
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // One digit presented for exactly one edge (receiver is in COLLECT).
    task automatic send(input logic [6:0] seg, input logic sof);
        SEG_IN    = seg;
        SEG_VALID = 1'b1;
        SEG_SOF   = sof;
        tick();
        SEG_VALID = 1'b0;
        SEG_SOF   = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [15:0] w,
                               input logic [3:0] bm, input logic fe);
        check({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
        check({tag, "_word"},  32'(WORD),      32'(w));
        check({tag, "_blank"}, 32'(BLANK_MASK), 32'(bm));
        check({tag, "_err"},   32'(FRAME_ERR), 32'(fe));
        check({tag, "_ready"}, 32'(SEG_READY), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_word"},  32'(WORD),       32'h0);
        check({tag, "_blank"}, 32'(BLANK_MASK), 32'h0);
        check({tag, "_err"},   32'(FRAME_ERR),  32'h0);
        check({tag, "_valid"}, 32'(OUT_VALID),  32'h0);
        check({tag, "_ready"}, 32'(SEG_READY),  32'h1);
        check({tag, "_state"}, 32'(state_dbg),  32'(COLLECT));
    endtask

    initial begin
        RESET_N   = 1'b0;
        SEG_IN    = 7'h7F;
        SEG_VALID = 1'b0;
        SEG_SOF   = 1'b0;
        OUT_READY = 1'b1;
        tick();
        tick();
        RESET_N = 1'b1;
        check_reset_vals("reset");

        // Frame 1234, consumer ready: OUT_VALID for exactly one cycle.
        send(7'h79, 1'b1);
        send(7'h24, 1'b0);
        send(7'h30, 1'b0);
        check("f1_not_yet", 32'(OUT_VALID), 32'd0);
        send(7'h19, 1'b0);
        check_frame("f1", 16'h1234, 4'b0000, 1'b0);
        check("f1_state", 32'(state_dbg), 32'(HOLD));
        tick();
        check("f1_valid_drop", 32'(OUT_VALID), 32'd0);
        check("f1_ready_back", 32'(SEG_READY), 32'd1);

        // Blank digit in slot 1.
        send(7'h12, 1'b0);
        send(7'h7F, 1'b0);
        send(7'h00, 1'b0);
        send(7'h10, 1'b0);
        check_frame("f2", 16'h5F89, 4'b0100, 1'b0);
        tick();

        // Illegal pattern in slot 1.
        send(7'h40, 1'b0);
        send(7'h55, 1'b0);
        send(7'h02, 1'b0);
        send(7'h78, 1'b0);
        check_frame("f3", 16'h0E67, 4'b0000, 1'b1);
        tick();
        check("f3_err_clear", 32'(FRAME_ERR), 32'd0);

        // Consumer stalls for 10 cycles while the sender keeps offering a digit.
        OUT_READY = 1'b0;
        send(7'h78, 1'b0);
        send(7'h02, 1'b0);
        send(7'h12, 1'b0);
        send(7'h19, 1'b0);
        check_frame("f4", 16'h7654, 4'b0000, 1'b0);
        SEG_IN    = 7'h40;
        SEG_VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_ready", 32'(SEG_READY), 32'd0);
            check("stall_valid", 32'(OUT_VALID), 32'd1);
            check("stall_word",  32'(WORD),      32'h7654);
        end
        OUT_READY = 1'b1;
        tick();
        check("release_valid", 32'(OUT_VALID), 32'd0);
        check("release_ready", 32'(SEG_READY), 32'd1);
        SEG_VALID = 1'b0;

        // No digit consumed during the stall: a plain frame starts at slot 0.
        send(7'h79, 1'b0);
        send(7'h79, 1'b0);
        send(7'h79, 1'b0);
        check("f5_not_yet", 32'(OUT_VALID), 32'd0);
        send(7'h79, 1'b0);
        check_frame("f5", 16'h1111, 4'b0000, 1'b0);
        tick();

        // SOF mid-frame discards the partial frame.
        send(7'h79, 1'b0);
        send(7'h24, 1'b0);
        send(7'h40, 1'b1);
        send(7'h40, 1'b0);
        send(7'h40, 1'b0);
        check("f6_restart", 32'(OUT_VALID), 32'd0);
        send(7'h40, 1'b0);
        check_frame("f6", 16'h0000, 4'b0000, 1'b0);
        tick();

        // Error and blank in a discarded partial frame do not leak through.
        send(7'h7F, 1'b0);
        send(7'h55, 1'b0);
        send(7'h79, 1'b1);
        send(7'h24, 1'b0);
        send(7'h30, 1'b0);
        send(7'h19, 1'b0);
        check_frame("f7", 16'h1234, 4'b0000, 1'b0);
        tick();

        // Reset mid-frame aborts it.
        send(7'h10, 1'b0);
        send(7'h10, 1'b0);
        send(7'h10, 1'b0);
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        check_reset_vals("midrst");
        send(7'h10, 1'b0);
        send(7'h00, 1'b0);
        send(7'h78, 1'b0);
        check("f8_not_yet", 32'(OUT_VALID), 32'd0);
        send(7'h02, 1'b0);
        check_frame("f8", 16'h9876, 4'b0000, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
